// File: rtl/ysyx_22040127_div.sv
// ysyx_22040127_div: multi-cycle radix-2 restoring divider for RV64M
// DIV/DIVU/REM/REMU. The start/stuck/ready handshake is shared with the
// Booth multiplier, so the EXU stalls on either unit in the same way.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   x, y           dividend / divisor, sampled only on the accept edge
//   div_signed     1 = signed operation, 0 = unsigned
//   div_type       start request, honoured only when idle
//   div_stuck      pipeline stall; blocks accept and holds ready
//   quotient       registered quotient
//   remainder      registered remainder
//   ready          registered result-valid flag
//   busy           high whenever an operation is in flight
//
// state   | meaning
// IDLE    | waiting for an accept; ready is cleared unless stalled
// DIV_ON  | one restoring iteration per cycle on {R,Q}
// DIV_FIX | apply sign correction and publish quotient/remainder
// DIV_OK  | raise ready, return to IDLE
module ysyx_22040127_div #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             div_signed,
    input  logic             div_type,
    input  logic             div_stuck,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_ON  = 2'd1,
        DIV_FIX = 2'd2,
        DIV_OK  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] ymag_q, ymag_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;

    logic             accept;
    logic             x_neg, y_neg;
    logic [WIDTH-1:0] x_mag, y_mag;
    logic [WIDTH:0]   r_sh;
    logic             sub_ok;
    logic [WIDTH-1:0] trial;

    assign accept = div_type & ~div_stuck;
    assign x_neg  = div_signed & x[WIDTH-1];
    assign y_neg  = div_signed & y[WIDTH-1];
    assign x_mag  = x_neg ? -x : x;
    assign y_mag  = y_neg ? -y : y;

    // The shifted partial remainder needs one extra bit: R < |y| only
    // bounds 2R+1 below 2|y|, which can exceed WIDTH bits.
    assign r_sh   = {r_q, q_q[WIDTH-1]};
    assign sub_ok = r_sh >= {1'b0, ymag_q};
    // When sub_ok the true difference is below |y|, so the low WIDTH bits
    // of the wrapped subtraction are exact.
    assign trial  = r_sh[WIDTH-1:0] - ymag_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        r_d         = r_q;
        q_d         = q_q;
        ymag_d      = ymag_q;
        negq_d      = negq_q;
        negr_d      = negr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    ready_d = 1'b0;
                    // Special cases preload {R,Q} with the final answer and
                    // pass through DIV_FIX uncorrected, which gives them the
                    // two-edge latency.
                    if (y == '0) begin
                        q_d     = ALL_ONES;
                        r_d     = x;
                        negq_d  = 1'b0;
                        negr_d  = 1'b0;
                        state_d = DIV_FIX;
                    end else if (div_signed && x == MIN_NEG && y == ALL_ONES) begin
                        q_d     = x;
                        r_d     = '0;
                        negq_d  = 1'b0;
                        negr_d  = 1'b0;
                        state_d = DIV_FIX;
                    end else begin
                        q_d     = x_mag;
                        r_d     = '0;
                        ymag_d  = y_mag;
                        negq_d  = x_neg ^ y_neg;
                        negr_d  = x_neg;
                        cnt_d   = '0;
                        state_d = DIV_ON;
                    end
                end else if (!div_stuck) begin
                    ready_d = 1'b0;
                end
            end
            DIV_ON: begin
                r_d   = sub_ok ? trial : r_sh[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], sub_ok};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                quotient_d  = negq_q ? -q_q : q_q;
                remainder_d = negr_q ? -r_q : r_q;
                state_d     = DIV_OK;
            end
            DIV_OK: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            r_q         <= '0;
            q_q         <= '0;
            ymag_q      <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            r_q         <= r_d;
            q_q         <= q_d;
            ymag_q      <= ymag_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ready     = ready_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ysyx_22040127_div.sv
module tb_ysyx_22040127_div;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] x, y;
    logic        div_signed, div_type, div_stuck;
    logic [63:0] quotient, remainder;
    logic        ready, busy;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_22040127_div #(.WIDTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .div_signed (div_signed),
        .div_type   (div_type),
        .div_stuck  (div_stuck),
        .quotient   (quotient),
        .remainder  (remainder),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V reference: truncating division, remainder takes dividend sign.
    task automatic ref_div(input logic [63:0] a, input logic [63:0] b, input bit s,
                           output logic [63:0] q, output logic [63:0] r, output int lat);
        longint sa, sb;
        lat = 66;
        if (b == 64'd0) begin
            q = ONES; r = a; lat = 2;
        end else if (s && a == MINV && b == ONES) begin
            q = a; r = 64'd0; lat = 2;
        end else if (s) begin
            sa = a; sb = b;
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Issues one operation, optionally disturbing the inputs while busy,
    // and checks latency, busy duration and results. Returns with ready
    // just observed high, before the following edge.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit s,
                          input bit disturb, input string tag);
        logic [63:0] eq, er;
        int          elat, lat, busy_cnt;
        ref_div(a, b, s, eq, er, elat);
        @(negedge clk);
        x = a; y = b; div_signed = s; div_type = 1'b1; div_stuck = 1'b0;
        @(posedge clk); #1;
        div_type = 1'b0;
        x = {$urandom, $urandom}; y = {$urandom, $urandom}; div_signed = ~s;
        check({tag, "_acc_ready"}, {63'd0, ready}, 64'd0);
        check({tag, "_acc_busy"},  {63'd0, busy},  64'd1);
        lat = 0; busy_cnt = 0;
        while (!ready && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
            if (disturb) begin
                div_type = lat[0];
                x = {$urandom, $urandom};
                y = {$urandom_range(0, 3), $urandom};
            end
        end
        div_type = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        check({tag, "_busycyc"}, 64'(busy_cnt), 64'(elat - 1));
        check({tag, "_quot"}, quotient, eq);
        check({tag, "_rem"},  remainder, er);
    endtask

    initial begin
        logic [63:0] a, b, hq, hr;
        rst = 1'b1; x = '0; y = '0; div_signed = 1'b0; div_type = 1'b0; div_stuck = 1'b0;
        #1;
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_busy",  {63'd0, busy},  64'd0);
        check("rst_quot",  quotient,  64'd0);
        check("rst_rem",   remainder, 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op(64'd100, 64'd7, 1'b0, 1'b0, "u100_7");
        run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, "sm7_2");
        run_op(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, "s7_m2");
        run_op(64'h1234, 64'd0, 1'b1, 1'b0, "dz_s");
        run_op(64'h1234, 64'd0, 1'b0, 1'b0, "dz_u");
        run_op(MINV, ONES, 1'b1, 1'b0, "ovf_s");
        run_op(MINV, ONES, 1'b0, 1'b0, "ovf_u");

        // Inputs thrashed while busy must not affect the result.
        run_op(64'd100, 64'd7, 1'b0, 1'b1, "disturb");
        // Stall after ready: ready and results hold.
        div_stuck = 1'b1;
        hq = quotient; hr = remainder;
        repeat (5) begin
            @(posedge clk); #1;
            check("stuck_ready", {63'd0, ready}, 64'd1);
            check("stuck_quot", quotient, hq);
            check("stuck_rem",  remainder, hr);
        end
        // Releasing the stall together with a new request restarts at once.
        run_op(64'd12345, 64'd3, 1'b0, 1'b0, "b2b");

        for (int i = 0; i < 24; i++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: b = 64'(int'($urandom_range(1, 1000)));
                1: b = -64'(int'($urandom_range(1, 1000)));
                2: b = 64'd0;
                3: b = {$urandom, $urandom};
                default: b = {32'd0, $urandom};
            endcase
            if (i == 5) begin a = MINV; b = ONES; end
            run_op(a, b, 1'($urandom_range(0, 1)), 1'b0, "rand");
        end

        // Asynchronous reset mid-operation.
        @(negedge clk);
        x = 64'd999_999; y = 64'd13; div_signed = 1'b0; div_type = 1'b1;
        @(posedge clk); #1;
        div_type = 1'b0;
        repeat (30) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_ready", {63'd0, ready}, 64'd0);
        check("arst_busy",  {63'd0, busy},  64'd0);
        check("arst_quot",  quotient,  64'd0);
        check("arst_rem",   remainder, 64'd0);
        @(negedge clk); rst = 1'b0;
        run_op(64'd1000, 64'd10, 1'b0, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
